// File: rtl/speech256_pkg.sv
// ---------------------------------------------------------------------------
// speech256_pkg
// Shared definitions for the Speech256 allophone sequencer:
//   ALLO_W          allophone code width
//   PA_MIN/PA_MAX   range of codes that are pauses
//   seq_state_e     sequencer FSM states
//   is_pause()      true when a code lies in the pause range
// ---------------------------------------------------------------------------
package speech256_pkg;

    localparam int ALLO_W = 6;

    localparam logic [ALLO_W-1:0] PA_MIN = 6'h00;
    localparam logic [ALLO_W-1:0] PA_MAX = 6'h04;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } seq_state_e;

    // PA_MIN is zero, so only the upper bound needs testing.
    function automatic logic is_pause(input logic [ALLO_W-1:0] code);
        return (code <= PA_MAX);
    endfunction

endpackage

// File: rtl/speech256_allo_fifo.sv
// ---------------------------------------------------------------------------
// speech256_allo_fifo
// Synchronous FIFO holding queued allophone codes.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i         write request (ignored when full or flushing)
//   wr_data_i       code to store
//   rd_en_i         pop request (ignored when empty or flushing)
//   flush_i         empty the FIFO; overrides any read/write that cycle
//   rd_data_o       current head (valid while not empty)
//   full_o/empty_o  occupancy flags
//   level_o         occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module speech256_allo_fifo
    import speech256_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ALLO_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic              flush_i,
    output logic [ALLO_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o
);

    logic [ALLO_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_wr;
    logic              do_rd;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_wr = wr_en_i && !full_o  && !flush_i;
    assign do_rd = rd_en_i && !empty_o && !flush_i;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/speech256_seq.sv
// ---------------------------------------------------------------------------
// speech256_seq
// Allophone sequencer in front of the Speech256 core. Queues host codes and
// feeds them to the core one per ldq request, optionally appending a pause
// at the end of a phrase.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_data       allophone code from host
//   wr_stb        one-cycle write strobe
//   flush         discard queued codes and any pending pause
//   full, level   FIFO full flag and occupancy (0..DEPTH)
//   overflow      sticky: a write was dropped while full (cleared by flush)
//   ldq           core load request, high = ready for next allophone
//   data_out      code presented to the core (held between strobes)
//   data_stb      one-cycle load strobe to the core
//   busy          phrase in progress
//   phrase_done   one-cycle pulse at end of phrase
//   ack_err       sticky: ldq stayed high ACK_TIMEOUT cycles after a strobe
// ---------------------------------------------------------------------------
module speech256_seq
    import speech256_pkg::*;
#(
    parameter int                DEPTH       = 16,
    parameter int                AW          = 4,
    parameter int                AUTO_PAUSE  = 1,
    parameter logic [ALLO_W-1:0] PAUSE_CODE  = 6'h03,
    parameter int                ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ALLO_W-1:0] wr_data,
    input  logic              wr_stb,
    input  logic              flush,
    output logic              full,
    output logic [AW:0]       level,
    output logic              overflow,
    input  logic              ldq,
    output logic [ALLO_W-1:0] data_out,
    output logic              data_stb,
    output logic              busy,
    output logic              phrase_done,
    output logic              ack_err
);

    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(ACK_TIMEOUT);

    seq_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic              busy_q, busy_d;
    logic              last_np_q, last_np_d;
    logic              stb_q, stb_d;
    logic [ALLO_W-1:0] dout_q, dout_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              ackerr_q, ackerr_d;

    logic              pop;
    logic              fifo_empty;
    logic [ALLO_W-1:0] head;
    logic              wr_accept;

    speech256_allo_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_stb),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .flush_i   (flush),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (fifo_empty),
        .level_o   (level)
    );

    assign wr_accept = wr_stb && !full && !flush;
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        last_np_d = last_np_q;
        stb_d     = 1'b0;
        dout_d    = dout_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        ackerr_d  = ackerr_q;
        pop       = 1'b0;

        // last_np doubles as the pending-pause flag, so flush clears it.
        if (flush) begin
            ovf_d     = 1'b0;
            last_np_d = 1'b0;
        end else if (wr_stb && full) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ldq) begin
                    if (!fifo_empty && !flush) begin
                        // Queued codes always go before a pending pause.
                        pop       = 1'b1;
                        dout_d    = head;
                        stb_d     = 1'b1;
                        busy_d    = 1'b1;
                        last_np_d = !is_pause(head);
                        cnt_d     = '0;
                        state_d   = WAIT_LOW;
                    end else if ((AUTO_PAUSE != 0) && last_np_q && !flush) begin
                        dout_d    = PAUSE_CODE;
                        stb_d     = 1'b1;
                        last_np_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = WAIT_LOW;
                    end else if (busy_q && !wr_accept) begin
                        // A write landing now keeps the phrase open.
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            WAIT_LOW: begin
                // flush deliberately does not leave this state: the code
                // already strobed into the core cannot be recalled.
                if (!ldq) begin
                    state_d = IDLE;
                end else if (ACK_TIMEOUT != 0) begin
                    if (cnt_inc == TO_LIM) begin
                        ackerr_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            last_np_q <= 1'b0;
            stb_q     <= 1'b0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ackerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            last_np_q <= last_np_d;
            stb_q     <= stb_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ackerr_q  <= ackerr_d;
        end
    end

    assign data_out    = dout_q;
    assign data_stb    = stb_q;
    assign busy        = busy_q;
    assign phrase_done = done_q;
    assign overflow    = ovf_q;
    assign ack_err     = ackerr_q;

endmodule

// File: tb/tb_speech256_seq.sv
module tb_speech256_seq;

    logic       clk;
    logic       rst;
    logic [5:0] wr_data;
    logic       wr_stb;
    logic       flush;
    logic       ldq;

    logic       full,  full_n;
    logic [4:0] level, level_n;
    logic       overflow, overflow_n;
    logic [5:0] data_out, data_out_n;
    logic       data_stb, data_stb_n;
    logic       busy, busy_n;
    logic       phrase_done, phrase_done_n;
    logic       ack_err, ack_err_n;

    int errors = 0;
    int checks = 0;

    logic [5:0] got[$];
    logic [5:0] got2[$];
    int         n_done;
    int         n_done2;

    speech256_seq #(
        .DEPTH(16), .AW(4), .AUTO_PAUSE(1), .PAUSE_CODE(6'h03), .ACK_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_stb(wr_stb), .flush(flush),
        .full(full), .level(level), .overflow(overflow), .ldq(ldq),
        .data_out(data_out), .data_stb(data_stb), .busy(busy),
        .phrase_done(phrase_done), .ack_err(ack_err)
    );

    speech256_seq #(
        .DEPTH(16), .AW(4), .AUTO_PAUSE(0), .PAUSE_CODE(6'h03), .ACK_TIMEOUT(15)
    ) u_np (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_stb(wr_stb), .flush(flush),
        .full(full_n), .level(level_n), .overflow(overflow_n), .ldq(ldq),
        .data_out(data_out_n), .data_stb(data_stb_n), .busy(busy_n),
        .phrase_done(phrase_done_n), .ack_err(ack_err_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] code);
        wr_data = code;
        wr_stb  = 1'b1;
        tick();
        wr_stb  = 1'b0;
    endtask

    // Core model: raise ldq, and after each strobe hold ldq low for low_len cycles.
    task automatic serve(input int budget, input int low_len);
        int low_cnt;
        low_cnt = 0;
        got.delete();
        got2.delete();
        n_done  = 0;
        n_done2 = 0;
        ldq = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (data_stb_n) got2.push_back(data_out_n);
            if (phrase_done_n) n_done2++;
            if (phrase_done) n_done++;
            if (data_stb) begin
                got.push_back(data_out);
                ldq = 1'b0;
                low_cnt = low_len;
            end else if (low_cnt > 0) begin
                low_cnt--;
                if (low_cnt == 0) ldq = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] at(input logic [5:0] q[$], input int i);
        return (i < q.size()) ? 32'(q[i]) : 32'hFF;
    endfunction

    initial begin
        logic [5:0] exp1 [5];
        int nst, ndn, low, first_err;

        exp1 = '{6'h13, 6'h02, 6'h0D, 6'h13, 6'h03};
        rst = 1'b1; wr_stb = 1'b0; wr_data = '0; flush = 1'b0; ldq = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_phrase_done", phrase_done, 0);
        chk("rst_data_stb", data_stb, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_np_level", level_n, 0);
        chk("rst_np_flags", {full_n, overflow_n, busy_n, ack_err_n}, 0);
        rst = 1'b0;

        // Mixed phrase ending in a pause code: no extra pause appended
        wr(6'h13); wr(6'h02); wr(6'h0D); wr(6'h13); wr(6'h03);
        chk("t1_level", level, 5);
        serve(320, 50);
        chk("t1_count", got.size(), 5);
        for (int i = 0; i < 5; i++) chk("t1_code", at(got, i), exp1[i]);
        chk("t1_done", n_done, 1);
        chk("t1_busy_after", busy, 0);

        // Auto pause appended after a non-pause code; not with AUTO_PAUSE=0
        ldq = 1'b0;
        wr(6'h1B); wr(6'h07);
        serve(220, 50);
        chk("t2_count", got.size(), 3);
        chk("t2_code0", at(got, 0), 6'h1B);
        chk("t2_code1", at(got, 1), 6'h07);
        chk("t2_pause", at(got, 2), 6'h03);
        chk("t2_done", n_done, 1);
        chk("t2_np_count", got2.size(), 2);
        chk("t2_np_code0", at(got2, 0), 6'h1B);
        chk("t2_np_code1", at(got2, 1), 6'h07);
        chk("t2_np_done", n_done2, 1);

        // Overflow: DEPTH+2 writes with the core not ready
        ldq = 1'b0;
        for (int i = 0; i < 18; i++) wr(6'(6'h05 + i));
        chk("t3_full", full, 1);
        chk("t3_level", level, 16);
        chk("t3_overflow", overflow, 1);
        serve(150, 3);
        chk("t3_count", got.size(), 17);
        for (int i = 0; i < 16; i++) chk("t3_code", at(got, i), 6'(6'h05 + i));
        chk("t3_pause", at(got, 16), 6'h03);
        chk("t3_np_count", got2.size(), 16);
        chk("t3_overflow_sticky", overflow, 1);

        // Flush after the second strobe, with a coincident write
        ldq = 1'b0;
        for (int i = 0; i < 8; i++) wr(6'(6'h10 + i));
        ldq = 1'b1;
        nst = 0; low = 0;
        for (int c = 0; c < 100 && nst < 2; c++) begin
            tick();
            if (data_stb) begin
                nst++;
                ldq = 1'b0;
                low = 5;
            end else if (low > 0) begin
                low--;
                if (low == 0) ldq = 1'b1;
            end
        end
        chk("t5_two_strobes", nst, 2);
        chk("t5_level_before", level, 6);
        wr_data = 6'h2A; wr_stb = 1'b1; flush = 1'b1;
        tick();
        wr_stb = 1'b0; flush = 1'b0;
        chk("t5_level_flushed", level, 0);
        chk("t5_overflow_cleared", overflow, 0);
        tick();
        chk("t5_wr_discarded", level, 0);
        ldq = 1'b1;
        nst = 0; ndn = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (data_stb) nst++;
            if (phrase_done) ndn++;
        end
        chk("t5_no_strobes", nst, 0);
        chk("t5_done", ndn, 1);
        chk("t5_busy", busy, 0);

        // Ack timeout with ldq held high
        ldq = 1'b0;
        wr(6'h20); wr(6'h21);
        ldq = 1'b1;
        nst = 0;
        for (int c = 0; c < 5 && nst == 0; c++) begin
            tick();
            if (data_stb) nst++;
        end
        chk("t4_first_stb", nst, 1);
        chk("t4_first_code", data_out, 6'h20);
        nst = 0; first_err = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (data_stb) nst++;
            if (ack_err && first_err == 0) first_err = k;
        end
        chk("t4_no_dup_stb", nst, 0);
        chk("t4_err_cycle", first_err, 15);
        tick();
        chk("t4_next_stb", data_stb, 1);
        chk("t4_next_code", data_out, 6'h21);
        ldq = 1'b0;
        tick(); tick();
        serve(80, 3);
        chk("t4_pause_count", got.size(), 1);
        chk("t4_pause_code", at(got, 0), 6'h03);
        chk("t4_done", n_done, 1);
        chk("t4_ack_sticky", ack_err, 1);

        // Reset mid-phrase while waiting for ldq to fall
        ldq = 1'b0;
        wr(6'h30); wr(6'h31);
        ldq = 1'b1;
        tick();
        chk("t6_stb", data_stb, 1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_level", level, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ack_err", ack_err, 0);
        chk("t6_data_out", data_out, 0);
        chk("t6_stb_done", {data_stb, phrase_done, full, overflow}, 0);
        nst = 0; ndn = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (data_stb) nst++;
            if (phrase_done) ndn++;
        end
        chk("t6_no_stb", nst, 0);
        chk("t6_no_done", ndn, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/speech256_seq.md
Name: speech256_seq

Overview:
Allophone sequencer placed in front of the Speech256 core. A host writes 6-bit allophone codes into an internal FIFO. The block then drives the core's ldq / data_in / data_stb load handshake, one allophone per ldq request, until the FIFO drains. It optionally appends a terminating pause, detects a stalled core, and flags end of phrase.

Parameters:
DEPTH, 16, FIFO depth in allophones; must be a power of 2, minimum 2.
AW, 4, log2(DEPTH).
AUTO_PAUSE, 1, 1 = append PAUSE_CODE when the FIFO drains after a non-pause code.
PAUSE_CODE, 6'h03, code appended by AUTO_PAUSE.
ACK_TIMEOUT, 1023, max cycles to wait for ldq to fall after a strobe; 0 disables the check.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_data  in  6  allophone code from host
wr_stb  in  1  one-cycle write strobe
flush  in  1  discard queued codes and any pending pause
full  out  1  FIFO full
level  out  AW+1  FIFO occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped
ldq  in  1  core load request, high = ready for next allophone
data_out  out  6  allophone code to core data_in
data_stb  out  1  one-cycle load strobe to core
busy  out  1  phrase in progress
phrase_done  out  1  one-cycle pulse at end of phrase
ack_err  out  1  sticky: ldq did not fall within ACK_TIMEOUT

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values:
  - FIFO empty, level=0, full=0.
  - overflow=0, ack_err=0, busy=0, phrase_done=0.
  - data_stb=0, data_out=6'h00.
  - state=IDLE, pend_pause=0, last_np=0.
  - Reset mid-phrase abandons the phrase; no phrase_done is generated.
- FIFO:
  - A write with wr_stb=1 and not full is stored.
  - A write while full is dropped and sets overflow.
  - Pop and write in the same cycle are both allowed; level is unchanged.
  - Pointers wrap modulo DEPTH.
- flush:
  - Empties the FIFO, clears pend_pause, and clears overflow.
  - A wr_stb in the same cycle is discarded.
  - Does not abort WAIT_LOW, because an already-strobed code cannot be recalled.
- FSM, states IDLE and WAIT_LOW:
  - IDLE, ldq=1, FIFO non-empty: pop head. Next cycle data_out=head and data_stb=1 for exactly one cycle. Set busy. Set last_np = (head > 6'h04). Go to WAIT_LOW.
  - IDLE, ldq=1, FIFO empty, AUTO_PAUSE=1, last_np=1: issue PAUSE_CODE the same way. Clear last_np. Go to WAIT_LOW.
  - IDLE, ldq=1, FIFO empty, nothing to issue, busy=1: pulse phrase_done for one cycle and clear busy in the same cycle.
  - WAIT_LOW: a counter runs from 0.
    - ldq=0 -> IDLE.
    - Counter reaches ACK_TIMEOUT with ldq still 1 -> set ack_err, go to IDLE.
  - A code is never strobed twice. Consecutive data_stb pulses are separated by at least one cycle of ldq=0, or by a timeout.
- Latency: wr_stb in cycle n, FIFO empty, IDLE, ldq=1 -> data_stb=1 in cycle n+2.
- Simultaneous events:
  - A write in the same cycle the FIFO goes empty counts as non-empty next cycle; no phrase_done is generated.
  - A write arriving while a pause is pending is issued first, and the pause is re-evaluated after it.
- data_out holds the last issued code between strobes.

Decomposition:
- Package speech256_pkg holds:
  - ALLO_W=6.
  - Pause code range constants PA_MIN=6'h00, PA_MAX=6'h04.
  - FSM state enum {IDLE, WAIT_LOW}.
- Sub-module speech256_allo_fifo: synchronous FIFO with wr/rd/flush, full, empty and level.
- The FSM, timeout counter and flags live in speech256_seq.

Test Plan:
- Write 0x13,0x02,0x0D,0x13,0x03. Core model drops ldq for 50 cycles after each strobe -> data_stb pulses carry 0x13,0x02,0x0D,0x13,0x03 in order, no extra pause (0x03 is a pause), phrase_done exactly once, busy low after.
- AUTO_PAUSE=1, write 0x1B,0x07 -> strobes 0x1B,0x07,0x03, then phrase_done. Rerun with AUTO_PAUSE=0 -> no 0x03.
- Write DEPTH+2 codes with ldq=0 -> full=1, level=DEPTH, overflow=1. Then release ldq -> exactly DEPTH codes issued, first DEPTH written.
- ldq held at 1 after a strobe, ACK_TIMEOUT=15 -> ack_err set 15 cycles after entering WAIT_LOW, next code strobed afterwards, no duplicate strobe before the timeout.
- Queue 8 codes, assert flush after the 2nd strobe -> no further strobes, level=0, phrase_done once after ldq returns high. wr_stb coincident with flush is discarded.
- rst asserted mid-phrase in WAIT_LOW -> next cycle all outputs at reset values, no phrase_done, level=0.
